// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter (m0 = CPU, m1 = SHA DMA) in front of one memory port.
// Latency: a request seen in IDLE reaches the slave the next cycle; one IDLE bubble separates transactions.
// Backpressure: the grant is held until s_mem_ready; the losing master waits with valid held.
//
// Ports: clk/rst_n (async active-low); m0_* / m1_* master request side (valid, addr, wdata,
// wstrb in; ready pulse, rdata out); s_mem_* slave side (muxed request out, ready/rdata in);
// grant (one-hot {m1,m0}), conflict_cnt (saturating IDLE collisions), arb_err (sticky timeout).
// Optional feature macro: ARB_TIMEOUT_EN enables the grant watchdog (TIMEOUT cycles).
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_mem_valid,
    input  logic [ADDR_W-1:0]     m0_mem_addr,
    input  logic [DATA_W-1:0]     m0_mem_wdata,
    input  logic [DATA_W/8-1:0]   m0_mem_wstrb,
    output logic                  m0_mem_ready,
    output logic [DATA_W-1:0]     m0_mem_rdata,
    input  logic                  m1_mem_valid,
    input  logic [ADDR_W-1:0]     m1_mem_addr,
    input  logic [DATA_W-1:0]     m1_mem_wdata,
    input  logic [DATA_W/8-1:0]   m1_mem_wstrb,
    output logic                  m1_mem_ready,
    output logic [DATA_W-1:0]     m1_mem_rdata,
    output logic                  s_mem_valid,
    output logic [ADDR_W-1:0]     s_mem_addr,
    output logic [DATA_W-1:0]     s_mem_wdata,
    output logic [DATA_W/8-1:0]   s_mem_wstrb,
    input  logic                  s_mem_ready,
    input  logic [DATA_W-1:0]     s_mem_rdata,
    output logic [1:0]            grant,
    output logic [15:0]           conflict_cnt,
    output logic                  arb_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEADBEEF);

    state_t      state_q, state_d;
    logic        rr_q, rr_d;          // 0: m0 wins the next collision, 1: m1 wins
    logic [1:0]  grant_q, grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo;                 // watchdog forces completion this cycle

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] wait_q, wait_d;
    logic       err_q, err_d;

    // wait_q counts completed grant cycles, so the TIMEOUT-th grant cycle sees TMO_LAST.
    assign tmo = (state_q != IDLE) && (wait_q == TMO_LAST) && !s_mem_ready;

    always_comb begin
        wait_d = (state_q == IDLE) ? 8'd0 : wait_q + 8'd1;
        err_d  = err_q | tmo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= 8'd0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign arb_err = err_q;
`else
    logic unused_timeout;

    assign tmo            = 1'b0;
    assign unused_timeout = (TIMEOUT != 0);
    assign arb_err        = 1'b0;
`endif

    // Next-state: arbitration happens only in IDLE; a grant ends on slave ready or abort.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (m0_mem_valid && m1_mem_valid) begin
                    state_d = rr_q ? GNT1 : GNT0;
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end else if (m0_mem_valid) begin
                    state_d = GNT0;
                end else if (m1_mem_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (s_mem_ready || tmo) begin
                    state_d = IDLE;
                    rr_d    = 1'b1;
                end
            end
            GNT1: begin
                if (s_mem_ready || tmo) begin
                    state_d = IDLE;
                    rr_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            GNT0:    grant_d = 2'b01;
            GNT1:    grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            grant_q <= 2'b00;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant        = grant_q;
    assign conflict_cnt = cnt_q;

    // Datapath mux follows the registered state, so an async reset clears it at once.
    // The idle master sees ready=0 and rdata=0; an abort returns ABORT_DATA.
    always_comb begin
        s_mem_valid  = 1'b0;
        s_mem_addr   = '0;
        s_mem_wdata  = '0;
        s_mem_wstrb  = '0;
        m0_mem_ready = 1'b0;
        m0_mem_rdata = '0;
        m1_mem_ready = 1'b0;
        m1_mem_rdata = '0;
        unique case (state_q)
            GNT0: begin
                s_mem_valid  = m0_mem_valid && !tmo;
                s_mem_addr   = m0_mem_addr;
                s_mem_wdata  = m0_mem_wdata;
                s_mem_wstrb  = m0_mem_wstrb;
                m0_mem_ready = s_mem_ready || tmo;
                m0_mem_rdata = tmo ? ABORT_DATA : s_mem_rdata;
            end
            GNT1: begin
                s_mem_valid  = m1_mem_valid && !tmo;
                s_mem_addr   = m1_mem_addr;
                s_mem_wdata  = m1_mem_wdata;
                s_mem_wstrb  = m1_mem_wstrb;
                m1_mem_ready = s_mem_ready || tmo;
                m1_mem_rdata = tmo ? ABORT_DATA : s_mem_rdata;
            end
            default: ;
        endcase
    end

endmodule
